// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } alu_state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per
// cycle over a shared 2*WIDTH accumulator; o_last flags the final iteration.
module seq_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_div;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;

    // Mul: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
    assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

    // Div: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
    assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_div_nxt = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign o_busy = r_busy;
    assign o_last = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_lo   = r_acc[WIDTH-1:0];
    assign o_hi   = r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_div  <= 1'b0;
        end else if (i_start) begin
            r_acc  <= {{WIDTH{1'b0}}, i_a};
            r_b    <= i_b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_div  <= i_div;
        end else if (r_busy) begin
            r_acc <= r_div ? w_div_nxt : w_mul_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_last)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU behind valid/ready: add/sub in one cycle, mul/div
// through the iterative core; results held until the consumer takes them.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_by_zero
);
    alu_state_t       r_state;
    alu_state_t       w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_dbz;
    logic             r_use_core;
    logic             r_mul;

    logic             w_accept;
    logic             w_iter;
    logic             w_dbz;
    logic             w_start;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_busy;
    logic             w_last;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;

    assign w_accept = in_valid && in_ready;
    assign w_dbz    = (sel == OP_DIV) && (inb == '0);
    assign w_iter   = (sel == OP_MUL) || ((sel == OP_DIV) && (inb != '0));
    assign w_start  = w_accept && w_iter;
    assign w_add    = {1'b0, ina} + {1'b0, inb};
    assign w_sub    = {1'b0, ina} - {1'b0, inb};

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_div   (sel == OP_DIV),
        .i_a     (ina),
        .i_b     (inb),
        .o_busy  (w_busy),
        .o_last  (w_last),
        .o_lo    (w_lo),
        .o_hi    (w_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_iter ? S_CALC : S_DONE;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Single-cycle results are registered here; iterative results stay in the core,
    // which holds its accumulator once it stops iterating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
            r_use_core <= 1'b0;
            r_mul      <= 1'b0;
        end else if (w_accept) begin
            r_use_core <= w_iter;
            r_mul      <= (sel == OP_MUL);
            r_dbz      <= w_dbz;
            case (sel)
                OP_ADD: begin
                    r_result <= w_add[WIDTH-1:0];
                    r_ovf    <= w_add[WIDTH];
                end
                OP_SUB: begin
                    r_result <= w_sub[WIDTH-1:0];
                    r_ovf    <= w_sub[WIDTH];
                end
                default: begin
                    r_result <= '1;
                    r_ovf    <= w_dbz;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE) && !w_busy;
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_use_core ? w_lo : r_result;
    assign overflow    = r_use_core ? (r_mul && (|w_hi)) : r_ovf;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus random traffic on a
// 16-bit instance, and a few operations on an 8-bit instance.
module tb_seq_alu;
    localparam int W  = 16;
    localparam int W8 = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, overflow, div_by_zero;
    logic [W-1:0] ina = '0, inb = '0, result;
    logic [1:0]   sel = 2'b00;

    logic          in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic          in_ready8, out_valid8, overflow8, div_by_zero8;
    logic [W8-1:0] ina8 = '0, inb8 = '0, result8;
    logic [1:0]    sel8 = 2'b00;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    seq_alu #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ina(ina8), .inb(inb8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .overflow(overflow8), .div_by_zero(div_by_zero8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint unsigned res;
        bit              ovf;
        bit              dbz;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sb[$];
    exp_t sb8[$];
    int   total = 0, passed = 0;
    bit   rdy_rand = 1'b0;

    // Reference: plain unsigned arithmetic on wide integers.
    function automatic exp_t model(longint unsigned a, longint unsigned b, bit [1:0] op, int w);
        longint unsigned m = (64'd1 << w) - 1;
        longint unsigned p;
        exp_t e;
        e.dbz = 1'b0; e.lat = 1; e.acc = 0; e.ovf = 1'b0; e.res = 0;
        case (op)
            2'd0: begin p = a + b; e.res = p & m; e.ovf = (p >> w) != 0; end
            2'd1: begin e.res = (a - b) & m; e.ovf = a < b; end
            2'd2: begin p = a * b; e.res = p & m; e.ovf = (p >> w) != 0; e.lat = w + 1; end
            default: begin
                if (b == 0) begin e.res = m; e.ovf = 1'b1; e.dbz = 1'b1; end
                else begin e.res = a / b; e.lat = w + 1; end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor for the 16-bit instance: checks hold stability and pops on retire.
    bit           seen = 1'b0;
    int           first = 0;
    logic [W-1:0] hr;
    logic         ho, hd;
    exp_t         em;
    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1; first = cyc; hr = result; ho = overflow; hd = div_by_zero;
            end else begin
                chk("hold_result", result, hr);
                chk("hold_flags", {overflow, div_by_zero}, {ho, hd});
                chk("hold_in_ready", in_ready, 0);
            end
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got %0h expected none (cycle %0d)", result, cyc);
                end else begin
                    em = sb.pop_front();
                    chk("result", result, em.res);
                    chk("overflow", overflow, em.ovf);
                    chk("div_by_zero", div_by_zero, em.dbz);
                    chk("latency", longint'(first - em.acc + 1), longint'(em.lat));
                end
            end
        end
    end

    // Monitor for the 8-bit instance (consumer always ready).
    exp_t em8;
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                total++;
                $display("FAIL unexpected_result8: got %0h expected none", result8);
            end else begin
                em8 = sb8.pop_front();
                chk("result8", result8, em8.res);
                chk("overflow8", overflow8, em8.ovf);
                chk("latency8", longint'(cyc - em8.acc + 1), longint'(em8.lat));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; ina = a; inb = b; sel = op;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            total++;
            $display("FAIL issue_timeout: in_ready %0b expected 1", in_ready);
        end else begin
            e = model(a, b, op, W);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic [1:0] op);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; ina8 = a; inb8 = b; sel8 = op;
        @(negedge clk);
        while (!in_ready8 && n < 300) begin @(negedge clk); n++; end
        if (!in_ready8) begin
            total++;
            $display("FAIL issue8_timeout: in_ready %0b expected 1", in_ready8);
        end else begin
            e = model(a, b, op, W8);
            e.acc = cyc + 1;
            sb8.push_back(e);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || sb8.size() != 0) && n < 1000) begin @(negedge clk); n++; end
        if (sb.size() != 0 || sb8.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: pending %0d/%0d expected 0", sb.size(), sb8.size());
        end
    endtask

    initial begin
        int n;
        bit [1:0] op;
        logic [W-1:0] a, b;

        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {overflow, div_by_zero}, 0);
        chk("rst_out_valid8", out_valid8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(16'hFFFF, 16'h0001, 2'b00);
        issue(16'h0005, 16'h0007, 2'b01);
        issue(16'h00FF, 16'h0101, 2'b10);
        issue(16'h0100, 16'h0100, 2'b10);
        issue(16'd100,  16'd7,    2'b11);
        issue(16'h1234, 16'h0000, 2'b11);
        drain();

        // Backpressure: result held, new requests ignored while stalled.
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0101, 2'b10);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_out_valid", out_valid, 1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1; ina = 16'd1; inb = 16'd2; sel = 2'b00;
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stall_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // Asynchronous reset in the middle of a multiply.
        issue(16'h1234, 16'h5678, 2'b10);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {overflow, div_by_zero}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd3, 16'd4, 2'b00);
        drain();

        // Random traffic with a randomly stalling consumer.
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(1, 15));
            issue(a, b, op);
        end
        drain();
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // 8-bit instance.
        issue8(8'h10, 8'h10, 2'b10);
        issue8(8'hFF, 8'h10, 2'b11);
        issue8(8'hF0, 8'h20, 2'b00);
        issue8(8'h37, 8'h00, 2'b11);
        for (int i = 0; i < 10; i++)
            issue8(8'($urandom), 8'($urandom_range(1, 255)), 2'($urandom_range(0, 3)));
        drain();

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size() + sb8.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", total);
        $fatal(1);
    end

endmodule
